// File: rtl/aes_sub_bytes_iter.sv
// rtl/aes_sub_bytes_iter.sv - Iterative handshaked AES SubBytes / InvSubBytes engine
//
// Substitutes a 128-bit AES state LANES bytes per clock using LANES S-box lanes.
// Each lane has a forward and an inverse S-box. The mode captured at accept
// selects between them for the whole block.
//
// Ports:
//   clk        clock; all state updates on posedge
//   rst        asynchronous active-high reset
//   in_valid   in_block / in_inv valid
//   in_ready   engine idle and able to accept a block
//   in_block   input state, byte0 = [127:120] ... byte15 = [7:0]
//   in_inv     0 = SubBytes, 1 = InvSubBytes, sampled with in_block
//   out_valid  out_block holds a finished result
//   out_ready  consumer accepts out_block
//   out_block  substituted state (work register), same byte order as in_block
//   busy       high while substitution is in progress
module aes_sub_bytes_iter #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy
);
    localparam int NCYC = 16 / LANES;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
        $error("aes_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [127:0]    work_q,  work_d;
    logic            mode_q,  mode_d;

    // GF(2^8) arithmetic over the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] a);
        logic [7:0] b;
        b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        int         idx;
        logic [7:0] lane_in;
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        mode_d  = mode_q;
        idx     = 0;
        lane_in = 8'h00;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_block;
                    mode_d  = in_inv;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Lane l rewrites byte cnt*LANES+l of the work register in place.
                for (int l = 0; l < LANES; l++) begin
                    idx     = int'(cnt_q) * LANES + l;
                    lane_in = work_q[127 - 8 * idx -: 8];
                    work_d[127 - 8 * idx -: 8] = mode_q ? sbox_inv(lane_in) : sbox_fwd(lane_in);
                end
                if (cnt_q == CW'(NCYC - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY);
    assign out_block = work_q;

endmodule
